// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: comma-based byte alignment controller.
// Acquires lane sync on COM runs and forwards payload bytes.
module rx_sync_ctrl #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter logic [7:0] IDL      = 8'h7C,
  parameter int         SYNC_CNT = 4,
  parameter int         WINDOW   = 16
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] state,
  output logic [2:0] loss_count
);

  localparam int CW = $clog2(SYNC_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    SYNCED = 2'd2
  } st_e;

  st_e           state_q, state_d;
  logic [CW-1:0] com_q, com_d;
  logic [WW-1:0] win_q, win_d;
  logic [2:0]    loss_q, loss_d;
  logic [7:0]    dout_q, dout_d;
  logic          vout_q, vout_d;
  logic          active_q, active_d;
  logic          is_com;

  assign is_com = (byte_in == COM);

  // Next-state, counter and payload-forwarding logic
  always_comb begin
    state_d = state_q;
    com_d   = com_q;
    win_d   = win_q;
    loss_d  = loss_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      com_d   = '0;
      win_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SEARCH;
        end
        SEARCH: begin
          if (byte_valid) begin
            if (!is_com) begin
              com_d = '0;
            end else if (com_q == CW'(SYNC_CNT - 1)) begin
              state_d = SYNCED;
              com_d   = '0;
              win_d   = '0;
            end else begin
              com_d = com_q + 1'b1;
            end
          end
        end
        SYNCED: begin
          if (byte_valid) begin
            if (is_com) begin
              win_d = '0;
            end else if (win_q == WW'(WINDOW - 1)) begin
              state_d = SEARCH;
              com_d   = '0;
              win_d   = '0;
              if (loss_q != 3'd7) begin
                loss_d = loss_q + 3'd1;
              end
            end else begin
              win_d = win_q + 1'b1;
              if (byte_in != IDL) begin
                vout_d = 1'b1;
                dout_d = byte_in;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          com_d   = '0;
          win_d   = '0;
        end
      endcase
    end
    active_d = (state_d == SYNCED);
  end

  // State, counters and output registers
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      com_q    <= '0;
      win_q    <= '0;
      loss_q   <= '0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      com_q    <= com_d;
      win_q    <= win_d;
      loss_q   <= loss_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      active_q <= active_d;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign active     = active_q;
  assign state      = state_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb_rx_sync_ctrl: directed self-checking bench
// for the comma alignment controller.
module tb_rx_sync_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [1:0] state;
  logic [2:0] loss_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_loss;

  rx_sync_ctrl dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .enable     (enable),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active     (active),
    .state      (state),
    .loss_count (loss_count)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic ck_st(input string tag,
                       input logic [1:0] s,
                       input logic a);
    chk({tag, ".state"}, {6'd0, state}, {6'd0, s});
    chk({tag, ".active"}, {7'd0, active}, {7'd0, a});
  endtask

  task automatic ck_out(input string tag,
                        input logic v,
                        input logic [7:0] d);
    chk({tag, ".vout"}, {7'd0, valid_out}, {7'd0, v});
    chk({tag, ".dout"}, data_out, d);
  endtask

  task automatic ck_loss(input string tag,
                         input logic [2:0] l);
    chk({tag, ".loss"}, {5'd0, loss_count}, {5'd0, l});
  endtask

  task automatic send(input logic v,
                      input logic [7:0] b);
    byte_valid = v;
    byte_in    = b;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic sync_up(input string tag);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'hBC);
      ck_st(tag, 2'd1, 1'b0);
    end
    send(1'b1, 8'hBC);
    ck_st(tag, 2'd2, 1'b1);
    chk({tag, ".vout"}, {7'd0, valid_out}, 8'd0);
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #1;
    ck_st("rst", 2'd0, 1'b0);
    ck_out("rst", 1'b0, 8'h00);
    ck_loss("rst", 3'd0);

    #11 reset = 1'b1;
    #2;
    ck_st("rel", 2'd0, 1'b0);
    @(posedge clk_4f);
    #1;
    enable = 1'b1;
    send(1'b0, 8'h00);
    ck_st("idle2search", 2'd1, 1'b0);

    // acquisition
    sync_up("acq");
    send(1'b1, 8'h55);
    ck_out("acq55", 1'b1, 8'h55);
    send(1'b1, 8'hAA);
    ck_out("acqAA", 1'b1, 8'hAA);

    // idle filtering and gaps (window now 2)
    send(1'b1, 8'h7C);
    ck_out("idl", 1'b0, 8'hAA);
    send(1'b1, 8'h11);
    ck_out("p11", 1'b1, 8'h11);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 8'h99);
      ck_out("gap", 1'b0, 8'h11);
    end
    send(1'b1, 8'h22);
    ck_out("p22", 1'b1, 8'h22);
    // window 5: ten more fill it to 15
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 8'h30 + 8'(i));
      ck_out("fill", 1'b1, 8'h30 + 8'(i));
      ck_st("fill", 2'd2, 1'b1);
    end
    send(1'b1, 8'h3A);
    ck_st("winloss", 2'd1, 1'b0);
    ck_out("winloss", 1'b0, 8'h39);
    ck_loss("winloss", 3'd1);

    // broken search
    send(1'b1, 8'hBC);
    send(1'b1, 8'hBC);
    send(1'b1, 8'hBC);
    send(1'b1, 8'h33);
    ck_st("brk33", 2'd1, 1'b0);
    chk("brk33.vout", {7'd0, valid_out}, 8'd0);
    sync_up("brk");

    // repeated sync loss, loss_count saturates
    exp_loss = 1;
    for (int r = 0; r < 8; r++) begin
      if (r > 0) sync_up("rep");
      for (int i = 0; i < 15; i++) begin
        send(1'b1, 8'h01 + 8'(i));
        ck_out("pay", 1'b1, 8'h01 + 8'(i));
      end
      send(1'b1, 8'h10);
      if (exp_loss < 7) exp_loss++;
      ck_st("loss", 2'd1, 1'b0);
      ck_out("loss", 1'b0, 8'h0F);
      ck_loss("loss", 3'(exp_loss));
    end

    // enable priority
    sync_up("en");
    enable = 1'b0;
    send(1'b1, 8'h5A);
    ck_st("endrop", 2'd0, 1'b0);
    ck_out("endrop", 1'b0, 8'h0F);
    ck_loss("endrop", 3'd7);
    enable = 1'b1;
    send(1'b0, 8'h00);
    ck_st("reen", 2'd1, 1'b0);

    // async reset mid-search
    send(1'b1, 8'hBC);
    send(1'b1, 8'hBC);
    #2 reset = 1'b0;
    #1;
    ck_st("arst", 2'd0, 1'b0);
    ck_out("arst", 1'b0, 8'h00);
    ck_loss("arst", 3'd0);
    #2 reset = 1'b1;
    send(1'b0, 8'h00);
    ck_st("post", 2'd1, 1'b0);
    sync_up("post");
    ck_loss("post", 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
